match_controller: RTL
=====================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter COUNTDOWN_FRAMES, default 60, sets frame_ticks per countdown step.
REQ-002 Parameter FRAMES_PER_SEC, default 60, sets frame_ticks per round-timer second.
REQ-003 Parameter ROUND_TIME_S, default 99, sets round length in seconds (1..99).
REQ-004 Parameter KO_HOLD_FRAMES, default 120, sets frame_ticks held in ROUND_END.
REQ-005 Parameter ROUNDS_TO_WIN, default 2, sets round wins needed for the match (1..3).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 start  input  1  level start button, already active-high.
REQ-010 player1_health, player2_health  input  3 each  current health; 0 means KO.
REQ-011 game_state  output  3  IDLE=0, ROUND_INIT=1, COUNTDOWN=2, FIGHT=3, ROUND_END=4, MATCH_END=5.
REQ-012 players_enable  output  1  high only in FIGHT; gates player input.
REQ-013 round_reset  output  1  one-cycle pulse re-initialising players and health.
REQ-014 countdown  output  2  pre-fight digit 3..1; 0 otherwise.
REQ-015 time_left  output  7  round seconds remaining.
REQ-016 p1_rounds, p2_rounds  output  2 each  round wins; saturate at ROUNDS_TO_WIN.
REQ-017 winner  output  2  00 none/draw, 01 P1, 10 P2; valid in ROUND_END and MATCH_END.

Function
REQ-018 start_rise = start high this cycle and low the previous cycle (internal 1-flop history); only start_rise acts.
REQ-019 IDLE: on start_rise, clear p1_rounds, p2_rounds, winner; next state ROUND_INIT.
REQ-020 ROUND_INIT: lasts exactly one cycle with round_reset=1; sets countdown=3, frame counter=0, time_left=ROUND_TIME_S; next state COUNTDOWN.
REQ-021 COUNTDOWN: the frame counter increments on each frame_tick; on the tick where it equals COUNTDOWN_FRAMES-1, it clears and countdown decrements.
REQ-022 COUNTDOWN: on the decrement from 1 to 0, the next state is FIGHT; total length is 3*COUNTDOWN_FRAMES ticks.
REQ-023 FIGHT: players_enable=1; on each frame_tick a second counter advances, and at FRAMES_PER_SEC-1 it clears and time_left decrements.
REQ-024 FIGHT KO check runs every cycle: both healths 0 gives a draw (winner=00); only P1 at 0 gives winner=10 and p2_rounds+1; only P2 at 0 gives winner=01 and p1_rounds+1; then ROUND_END.
REQ-025 FIGHT timeout when time_left reaches 0: the higher health wins the round (counted as in REQ-024); equal health is a draw; then ROUND_END.
REQ-026 A KO and the final second decrement in the same cycle are scored as a KO; time_left still decrements.
REQ-027 The round counter update and the transition to ROUND_END occur on the same edge; players_enable=0 from the following cycle.
REQ-028 ROUND_END: hold counter counts KO_HOLD_FRAMES frame_ticks, then go to MATCH_END if either round count equals ROUNDS_TO_WIN, else to ROUND_INIT.
REQ-029 MATCH_END: winner shows the match winner (player with ROUNDS_TO_WIN rounds) and holds; start_rise clears rounds and winner and goes to ROUND_INIT.
REQ-030 start_rise is ignored in ROUND_INIT, COUNTDOWN, FIGHT and ROUND_END.
REQ-031 frame_tick in ROUND_INIT and IDLE is ignored; counters do not advance outside their owning state.
REQ-032 Unused encodings 6 and 7 go to IDLE on the next edge.

Reset
REQ-033 rst=1 at an edge: game_state=IDLE, players_enable=0, round_reset=0, countdown=0, time_left=ROUND_TIME_S, rounds=0, winner=00, all counters 0, start history=1 (a button held through reset does not start a match).
REQ-034 Reset mid-operation (any state) takes effect on the same edge with no partial scoring.

Verification
REQ-035 Bench parameters: COUNTDOWN_FRAMES=2, FRAMES_PER_SEC=2, ROUND_TIME_S=3, KO_HOLD_FRAMES=2, ROUNDS_TO_WIN=2; frame_tick every 4th cycle.
REQ-036 Start from IDLE -> one round_reset pulse, countdown 3,2,1 each for 2 ticks, FIGHT after 6 ticks, time_left=3.
REQ-037 In FIGHT set player2_health=0 -> next edge: game_state=4, p1_rounds=1, winner=01; 2 ticks later game_state=1.
REQ-038 P1 KOs P2 twice -> game_state=5, p1_rounds=2, winner=01; start_rise -> rounds 0, game_state=1.
REQ-039 Timeout with healths 4/4 -> after 6 ticks in FIGHT, winner=00, rounds unchanged; with 5/2 -> p1_rounds+1.
REQ-040 Both healths 0 on the same cycle as the last timer tick -> draw, time_left=0; rst during FIGHT -> IDLE and all outputs at reset values next cycle.

Source files
------------

// File: rtl/match_controller.sv
// match_controller: fighting-game match sequencer.
// Drives countdown, round timer, KO/timeout scoring and match wins.
module match_controller #(
    parameter int COUNTDOWN_FRAMES = 60,
    parameter int FRAMES_PER_SEC   = 60,
    parameter int ROUND_TIME_S     = 99,
    parameter int KO_HOLD_FRAMES   = 120,
    parameter int ROUNDS_TO_WIN    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [2:0] player1_health,
    input  logic [2:0] player2_health,
    output logic [2:0] game_state,
    output logic       players_enable,
    output logic       round_reset,
    output logic [1:0] countdown,
    output logic [6:0] time_left,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ROUND_INIT = 3'd1,
        S_COUNTDOWN  = 3'd2,
        S_FIGHT      = 3'd3,
        S_ROUND_END  = 3'd4,
        S_MATCH_END  = 3'd5
    } state_t;

    localparam int CDW = $clog2(COUNTDOWN_FRAMES + 1);
    localparam int SCW = $clog2(FRAMES_PER_SEC + 1);
    localparam int HDW = $clog2(KO_HOLD_FRAMES + 1);
    localparam logic [CDW-1:0] CD_LAST    = CDW'(COUNTDOWN_FRAMES - 1);
    localparam logic [SCW-1:0] SEC_LAST   = SCW'(FRAMES_PER_SEC - 1);
    localparam logic [HDW-1:0] HOLD_LAST  = HDW'(KO_HOLD_FRAMES - 1);
    localparam logic [6:0]     ROUND_TIME = 7'(ROUND_TIME_S);
    localparam logic [1:0]     RTW        = 2'(ROUNDS_TO_WIN);

    state_t         state, state_n;
    logic           start_q;
    logic [CDW-1:0] cd_cnt, cd_cnt_n;
    logic [SCW-1:0] sec_cnt, sec_cnt_n;
    logic [HDW-1:0] hold_cnt, hold_cnt_n;
    logic [1:0]     countdown_n;
    logic [6:0]     time_n;
    logic [1:0]     p1_n, p2_n, win_n;
    logic [1:0]     round_win;
    logic           start_rise, sec_wrap, last_sec, any_ko, match_won;

    assign start_rise = start & ~start_q;
    assign sec_wrap   = frame_tick && (sec_cnt == SEC_LAST);
    assign last_sec   = sec_wrap && (time_left <= 7'd1);
    assign any_ko     = (player1_health == 3'd0) || (player2_health == 3'd0);
    assign match_won  = (p1_rounds == RTW) || (p2_rounds == RTW);

    assign game_state     = state;
    assign players_enable = (state == S_FIGHT);
    assign round_reset    = (state == S_ROUND_INIT);

    // KO and timeout share one rule: zero health always loses to non-zero
    always_comb begin
        round_win = 2'b00;
        unique case (1'b1)
            player1_health > player2_health: round_win = 2'b01;
            player1_health < player2_health: round_win = 2'b10;
            default:                         round_win = 2'b00;
        endcase
    end

    always_comb begin
        state_n     = state;
        cd_cnt_n    = cd_cnt;
        sec_cnt_n   = sec_cnt;
        hold_cnt_n  = hold_cnt;
        countdown_n = countdown;
        time_n      = time_left;
        p1_n        = p1_rounds;
        p2_n        = p2_rounds;
        win_n       = winner;
        case (state)
            S_IDLE, S_MATCH_END: begin
                if (start_rise) begin
                    p1_n    = 2'd0;
                    p2_n    = 2'd0;
                    win_n   = 2'b00;
                    state_n = S_ROUND_INIT;
                end
            end
            S_ROUND_INIT: begin
                countdown_n = 2'd3;
                cd_cnt_n    = '0;
                sec_cnt_n   = '0;
                time_n      = ROUND_TIME;
                state_n     = S_COUNTDOWN;
            end
            S_COUNTDOWN: begin
                if (frame_tick) begin
                    if (cd_cnt == CD_LAST) begin
                        cd_cnt_n    = '0;
                        countdown_n = countdown - 2'd1;
                        if (countdown == 2'd1) begin
                            sec_cnt_n = '0;
                            state_n   = S_FIGHT;
                        end
                    end else begin
                        cd_cnt_n = cd_cnt + CDW'(1);
                    end
                end
            end
            S_FIGHT: begin
                if (frame_tick) begin
                    sec_cnt_n = sec_wrap ? '0 : sec_cnt + SCW'(1);
                    if (sec_wrap && time_left != 7'd0)
                        time_n = time_left - 7'd1;
                end
                if (any_ko || last_sec) begin
                    win_n      = round_win;
                    hold_cnt_n = '0;
                    state_n    = S_ROUND_END;
                    if (round_win == 2'b01 && p1_rounds != RTW)
                        p1_n = p1_rounds + 2'd1;
                    if (round_win == 2'b10 && p2_rounds != RTW)
                        p2_n = p2_rounds + 2'd1;
                end
            end
            S_ROUND_END: begin
                if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt_n = '0;
                        if (match_won) begin
                            win_n   = (p1_rounds == RTW) ? 2'b01 : 2'b10;
                            state_n = S_MATCH_END;
                        end else begin
                            state_n = S_ROUND_INIT;
                        end
                    end else begin
                        hold_cnt_n = hold_cnt + HDW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Start history resets high so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b1;
            cd_cnt    <= '0;
            sec_cnt   <= '0;
            hold_cnt  <= '0;
            countdown <= 2'd0;
            time_left <= ROUND_TIME;
            p1_rounds <= 2'd0;
            p2_rounds <= 2'd0;
            winner    <= 2'b00;
        end else begin
            state     <= state_n;
            start_q   <= start;
            cd_cnt    <= cd_cnt_n;
            sec_cnt   <= sec_cnt_n;
            hold_cnt  <= hold_cnt_n;
            countdown <= countdown_n;
            time_left <= time_n;
            p1_rounds <= p1_n;
            p2_rounds <= p2_n;
            winner    <= win_n;
        end
    end
endmodule
